mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 127 ++++++++++++
 tb/tb_mem_access_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store handshake between EX/MEM and a single-outstanding memory port.
// One BUSY phase per access, bounded by TIMEOUT_CYCLES; the upstream pipeline is stalled until the ack.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] ALUres_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        WB_i,
  input  logic        WBSrc_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        err_o,
  output logic [31:0] MemRdata_o,
  output logic [31:0] ALUres_o,
  output logic [4:0]  rd_addr_o,
  output logic        WB_o,
  output logic        WBSrc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          to_q, to_d;

  logic op, aligned, access, misalign;

  always_comb begin
    op       = MemRead_i | MemWrite_i;
    aligned  = (addr_i[1:0] == 2'b00);
    access   = (state_q == IDLE) && op && aligned;
    misalign = (state_q == IDLE) && op && !aligned;

    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    to_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          state_d = BUSY;
          cnt_d   = '0;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          we_d    = MemWrite_i;  // read+write together counts as a store
        end else if (misalign) begin
          err_d = 1'b1;
        end
      end
      BUSY: begin
        // An ack arriving on the last allowed cycle still completes normally.
        if (mem_ack_i) begin
          state_d = DONE;
          if (!we_q) rdata_d = mem_rdata_i;
        end else if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign mem_req_o   = (state_q == BUSY);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign MemRdata_o  = rdata_q;
  assign err_o       = err_q;
  assign stall_o     = access | (state_q == BUSY);
  // to_q is only ever set for the DONE cycle that follows a timeout.
  assign WB_o        = WB_i & ~stall_o & ~(misalign | to_q);
  assign ALUres_o    = ALUres_i;
  assign rd_addr_o   = rd_addr_i;
  assign WBSrc_o     = WBSrc_i;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, misalign, timeout, reset abort, back-to-back.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        MemRead_i, MemWrite_i;
  logic [31:0] addr_i, wdata_i, ALUres_i;
  logic [4:0]  rd_addr_i;
  logic        WB_i, WBSrc_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        stall_o, err_o;
  logic [31:0] MemRdata_o, ALUres_o;
  logic [4:0]  rd_addr_o;
  logic        WB_o, WBSrc_o;

  int compared   = 0;
  int mismatched = 0;
  int req_rises  = 0;
  int stall_cnt;
  logic prev_req = 1'b0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_rd;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ALUres_i(ALUres_i),
    .rd_addr_i(rd_addr_i), .WB_i(WB_i), .WBSrc_i(WBSrc_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .err_o(err_o),
    .MemRdata_o(MemRdata_o), .ALUres_o(ALUres_o),
    .rd_addr_o(rd_addr_o), .WB_o(WB_o), .WBSrc_o(WBSrc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1ns after the edge; also counts new memory requests.
  task automatic step();
    @(posedge clk_i);
    #1;
    if (mem_req_o && !prev_req) req_rises++;
    prev_req = mem_req_o;
  endtask

  initial begin
    rst_i = 1'b0; MemRead_i = 0; MemWrite_i = 0; addr_i = 0; wdata_i = 0;
    ALUres_i = 0; rd_addr_i = 0; WB_i = 0; WBSrc_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    step(); step();
    chk("rst_req", mem_req_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_wdata", mem_wdata_o, 0);
    chk("rst_rdata", MemRdata_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_stall", stall_o, 0);
    rst_i = 1'b1;
    step();

    ALUres_i = 32'hA5A5_0001; rd_addr_i = 5'd7; WBSrc_i = 1'b1; WB_i = 1'b1;
    #1;
    chk("pass_alu", ALUres_o, 32'hA5A5_0001);
    chk("pass_rd", rd_addr_o, 7);
    chk("pass_wbsrc", WBSrc_o, 1);
    chk("pass_wb_idle", WB_o, 1);

    // Load at 0x10, ack on the third BUSY cycle.
    MemRead_i = 1; addr_i = 32'h10; WB_i = 1;
    sb_q.push_back(32'hDEAD_BEEF);
    stall_cnt = 0;
    #1;
    if (stall_o) stall_cnt++;
    chk("ld_req_detect", mem_req_o, 0);
    chk("ld_wb_stalled", WB_o, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      mem_ack_i = (i == 2);
      mem_rdata_i = (i == 2) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      #1;
      if (stall_o) stall_cnt++;
      chk("ld_req_busy", mem_req_o, 1);
      chk("ld_addr", mem_addr_o, 32'h10);
      chk("ld_we", mem_we_o, 0);
    end
    step();
    mem_ack_i = 0;
    #1;
    if (stall_o) stall_cnt++;
    chk("ld_stall_cycles", stall_cnt, 4);
    chk("ld_done_req", mem_req_o, 0);
    exp_rd = sb_q.pop_front();
    chk("ld_rdata", MemRdata_o, exp_rd);
    chk("ld_done_wb", WB_o, 1);
    chk("ld_done_err", err_o, 0);
    MemRead_i = 0;
    step();

    // Store at 0x20; upstream inputs scrambled during BUSY must not disturb the request.
    MemWrite_i = 1; addr_i = 32'h20; wdata_i = 32'h1234_5678; WB_i = 0;
    step();
    addr_i = 32'hFFFF_FFF0; wdata_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      mem_ack_i = (i == 1);
      mem_rdata_i = 32'h5555_5555;
      #1;
      chk("st_req", mem_req_o, 1);
      chk("st_we", mem_we_o, 1);
      chk("st_addr", mem_addr_o, 32'h20);
      chk("st_wdata", mem_wdata_o, 32'h1234_5678);
      step();
    end
    mem_ack_i = 0;
    #1;
    chk("st_done_req", mem_req_o, 0);
    chk("st_rdata_kept", MemRdata_o, 32'hDEAD_BEEF);
    chk("st_done_err", err_o, 0);
    MemWrite_i = 0;
    step();

    // Misaligned load at 0x22.
    MemRead_i = 1; addr_i = 32'h22; WB_i = 1;
    #1;
    chk("mis_req", mem_req_o, 0);
    chk("mis_stall", stall_o, 0);
    chk("mis_wb", WB_o, 0);
    chk("mis_err_now", err_o, 0);
    step();
    MemRead_i = 0;
    #1;
    chk("mis_err_next", err_o, 1);
    chk("mis_req_next", mem_req_o, 0);
    chk("mis_wb_next", WB_o, 1);
    step();
    chk("mis_err_clear", err_o, 0);

    // Timeout: no ack, four BUSY cycles then an erroring DONE.
    MemRead_i = 1; addr_i = 32'h30; WB_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_req_busy", mem_req_o, 1);
    end
    step();
    chk("to_done_req", mem_req_o, 0);
    chk("to_done_err", err_o, 1);
    chk("to_done_wb", WB_o, 0);
    chk("to_done_stall", stall_o, 0);
    chk("to_rdata_kept", MemRdata_o, 32'hDEAD_BEEF);
    MemRead_i = 0;
    step();
    chk("to_idle_err", err_o, 0);
    chk("to_idle_req", mem_req_o, 0);

    // Ack on the timeout cycle completes normally.
    MemRead_i = 1; addr_i = 32'h40; WB_i = 1;
    sb_q.push_back(32'hCAFE_F00D);
    for (int i = 0; i < 4; i++) begin
      step();
      mem_ack_i = (i == 3);
      mem_rdata_i = 32'hCAFE_F00D;
    end
    step();
    mem_ack_i = 0;
    #1;
    exp_rd = sb_q.pop_front();
    chk("race_rdata", MemRdata_o, exp_rd);
    chk("race_err", err_o, 0);
    chk("race_wb", WB_o, 1);
    MemRead_i = 0;
    step();

    // Ack while idle is ignored.
    mem_ack_i = 1; mem_rdata_i = 32'h1111_1111;
    step();
    mem_ack_i = 0;
    #1;
    chk("idle_ack_ignored", MemRdata_o, 32'hCAFE_F00D);

    // Reset in the middle of BUSY, then a stale ack.
    MemRead_i = 1; addr_i = 32'h50; WB_i = 1;
    step(); step();
    chk("rb_busy", mem_req_o, 1);
    rst_i = 0;
    step();
    chk("rb_req", mem_req_o, 0);
    chk("rb_rdata", MemRdata_o, 0);
    chk("rb_stall_in_rst", stall_o, 1);
    MemRead_i = 0;
    #1;
    chk("rb_stall_follow", stall_o, 0);
    rst_i = 1;
    mem_ack_i = 1; mem_rdata_i = 32'h9999_9999;
    step();
    mem_ack_i = 0;
    #1;
    chk("rb_ack_ignored", MemRdata_o, 0);
    chk("rb_req_after", mem_req_o, 0);

    // Back-to-back loads 0x10 then 0x14, single-cycle ack each.
    req_rises = 0;
    MemRead_i = 1; addr_i = 32'h10; WB_i = 1;
    sb_q.push_back(32'hAAAA_0001);
    sb_q.push_back(32'hBBBB_0002);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("b2b_addr", mem_addr_o, (k == 0) ? 32'h10 : 32'h14);
      mem_ack_i = 1;
      mem_rdata_i = (k == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002;
      step();
      mem_ack_i = 0;
      #1;
      exp_rd = sb_q.pop_front();
      chk("b2b_rdata", MemRdata_o, exp_rd);
      chk("b2b_done_stall", stall_o, 0);
      chk("b2b_done_wb", WB_o, 1);
      step();
      addr_i = 32'h14;
      if (k == 1) MemRead_i = 0;
    end
    step();
    chk("b2b_req_count", req_rises, 2);
    chk("b2b_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
